// File: rtl/wdt_ctrl_pkg.sv
// wdt_ctrl_pkg
//   Shared definitions for the watchdog recovery controller:
//   FSM state encodings (3-bit, readable over o_state) and the blanking
//   margin added on top of a clear pulse before i_wdt_timeout is trusted.
package wdt_ctrl_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_RST     = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_ARM     = S_ARM,
    ST_RUN     = S_RUN,
    ST_RST     = S_RST,
    ST_RECOVER = S_RECOVER,
    ST_FAULT   = S_FAULT
  } state_e;

  // Extra cycles of timeout blanking after a clear pulse; covers the WDT's
  // clear synchronizer plus its flag update latency.
  localparam int BLANK_MARGIN = 4;

endpackage

// File: rtl/wdt_recovery_ctrl_tick_gen.sv
// wdt_tick_gen
//   Free-running divider producing the WDT count clock and a one-cycle tick.
//   Ports:
//     i_clk, i_rst : system clock, async active-high reset
//     o_cnt_clk    : registered square wave, high for the upper half of the
//                    divide period
//     o_tick       : one-cycle pulse on the last count of each period
module wdt_tick_gen #(
  parameter int CLK_DIV = 25000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_cnt_clk,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_q, div_d;
  logic          clk_q;

  always_comb begin
    div_d = (div_q == CW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
  end

  // The square wave is computed from the next count so it is registered
  // yet still lines up with the current count value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      clk_q <= (div_d >= CW'(CLK_DIV / 2));
    end
  end

  assign o_cnt_clk = clk_q;
  assign o_tick    = (div_q == CW'(CLK_DIV - 1));

endmodule

// File: rtl/wdt_recovery_ctrl.sv
// wdt_recovery_ctrl
//   Supervisory controller for a WDT counter: generates its count clock and
//   enable, turns heartbeat kicks into clear pulses, and on timeout issues a
//   bounded number of system reset requests before latching a sticky fault.
//   Ports:
//     i_clk, i_rst   : system clock, async active-high reset
//     i_enable       : policy enable (sync)
//     i_kick         : async heartbeat, rising edge = kick
//     i_fault_clr    : async, rising edge clears FAULT
//     i_wdt_timeout  : WDT timeout flag (sync)
//     o_wdt_en       : WDT count enable
//     o_wdt_cnt_clk  : WDT count clock
//     o_wdt_cnt_clr  : WDT clear pulse
//     o_sys_rst_req  : system reset request
//     o_fault        : sticky fault
//     o_retry_cnt    : reset attempts issued
//     o_state        : FSM state readback
module wdt_recovery_ctrl
  import wdt_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = 25000,
  parameter int CLR_PULSE_CYC = 4,
  parameter int RST_PULSE_CYC = 100,
  parameter int RECOVER_TICKS = 30,
  parameter int MAX_RETRY     = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_kick,
  input  logic       i_fault_clr,
  input  logic       i_wdt_timeout,
  output logic       o_wdt_en,
  output logic       o_wdt_cnt_clk,
  output logic       o_wdt_cnt_clr,
  output logic       o_sys_rst_req,
  output logic       o_fault,
  output logic [3:0] o_retry_cnt,
  output logic [2:0] o_state
);

  localparam int CCW = $clog2(CLR_PULSE_CYC + 1);
  localparam int BCW = $clog2(CLR_PULSE_CYC + BLANK_MARGIN + 1);
  localparam int RCW = $clog2(RST_PULSE_CYC + 1);
  localparam int TCW = $clog2(RECOVER_TICKS + 1);

  // ---------------- tick generator ----------------
  logic tick;

  wdt_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .o_cnt_clk(o_wdt_cnt_clk),
    .o_tick   (tick)
  );

  // ---------------- synchronizers + edge detect ----------------
  // Edge pulses are registered, so they appear 3 cycles after the input edge.
  logic kick_s1_q, kick_s2_q, kick_s3_q, kick_edge_q;
  logic fclr_s1_q, fclr_s2_q, fclr_s3_q, fclr_edge_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      kick_s1_q   <= 1'b0;
      kick_s2_q   <= 1'b0;
      kick_s3_q   <= 1'b0;
      kick_edge_q <= 1'b0;
      fclr_s1_q   <= 1'b0;
      fclr_s2_q   <= 1'b0;
      fclr_s3_q   <= 1'b0;
      fclr_edge_q <= 1'b0;
    end else begin
      kick_s1_q   <= i_kick;
      kick_s2_q   <= kick_s1_q;
      kick_s3_q   <= kick_s2_q;
      kick_edge_q <= kick_s2_q & ~kick_s3_q;
      fclr_s1_q   <= i_fault_clr;
      fclr_s2_q   <= fclr_s1_q;
      fclr_s3_q   <= fclr_s2_q;
      fclr_edge_q <= fclr_s2_q & ~fclr_s3_q;
    end
  end

  // ---------------- FSM ----------------
  state_e         state_q, state_d;
  logic [3:0]     retry_q, retry_d;
  logic [CCW-1:0] clr_cnt_q, clr_cnt_d;
  logic [BCW-1:0] blank_q, blank_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TCW-1:0] rec_q, rec_d;
  logic           clr_start, clr_abort;
  logic           wdt_en_q, clr_o_q, rst_req_q, fault_q;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    rst_cnt_d = rst_cnt_q;
    rec_d     = rec_q;
    clr_start = 1'b0;
    clr_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d   = ST_ARM;
          clr_start = 1'b1;
        end
      end
      ST_ARM: begin
        if (!i_enable) begin
          state_d   = ST_IDLE;
          clr_abort = 1'b1;
          retry_d   = '0;
        end else if (clr_cnt_q <= CCW'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d   = ST_IDLE;
          clr_abort = 1'b1;
          retry_d   = '0;
        end else if (i_wdt_timeout && (blank_q == '0)) begin
          // Timeout beats a same-cycle kick: no clear is started here.
          if (retry_q < 4'(MAX_RETRY)) begin
            state_d   = ST_RST;
            retry_d   = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
            rst_cnt_d = RCW'(RST_PULSE_CYC);
          end else begin
            state_d = ST_FAULT;
          end
        end else if (kick_edge_q) begin
          clr_start = 1'b1;
        end
      end
      ST_RST: begin
        // Enable is only sampled once the pulse has fully completed.
        if (rst_cnt_q <= RCW'(1)) begin
          rst_cnt_d = '0;
          if (i_enable) begin
            state_d = ST_RECOVER;
            rec_d   = TCW'(RECOVER_TICKS);
          end else begin
            state_d = ST_IDLE;
            retry_d = '0;
          end
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      ST_RECOVER: begin
        if (!i_enable) begin
          state_d   = ST_IDLE;
          clr_abort = 1'b1;
          retry_d   = '0;
        end else if (tick) begin
          if (rec_q <= TCW'(1)) begin
            state_d   = ST_ARM;
            clr_start = 1'b1;
            rec_d     = '0;
          end else begin
            rec_d = rec_q - 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (fclr_edge_q) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- clear pulse engine ----------------
  always_comb begin
    clr_cnt_d = clr_cnt_q;
    blank_d   = blank_q;
    if (clr_abort) begin
      clr_cnt_d = '0;
      blank_d   = '0;
    end else if (clr_start && (clr_cnt_q == '0)) begin
      clr_cnt_d = CCW'(CLR_PULSE_CYC);
      blank_d   = BCW'(CLR_PULSE_CYC + BLANK_MARGIN);
    end else begin
      if (clr_cnt_q != '0) clr_cnt_d = clr_cnt_q - 1'b1;
      if (blank_q != '0)   blank_d   = blank_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      clr_cnt_q <= '0;
      blank_q   <= '0;
      rst_cnt_q <= '0;
      rec_q     <= '0;
      wdt_en_q  <= 1'b0;
      clr_o_q   <= 1'b0;
      rst_req_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      clr_cnt_q <= clr_cnt_d;
      blank_q   <= blank_d;
      rst_cnt_q <= rst_cnt_d;
      rec_q     <= rec_d;
      // Outputs decoded from next state so they track state_q exactly.
      wdt_en_q  <= (state_d == ST_RUN);
      clr_o_q   <= (clr_cnt_d != '0);
      rst_req_q <= (state_d == ST_RST);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign o_wdt_en      = wdt_en_q;
  assign o_wdt_cnt_clr = clr_o_q;
  assign o_sys_rst_req = rst_req_q;
  assign o_fault       = fault_q;
  assign o_retry_cnt   = retry_q;
  assign o_state       = state_q;

endmodule
